column_scan_driver: RTL and testbench
=====================================

# column_scan_driver

Time-multiplexed column scanner for the 24-column × 7-row LED word panel, sitting directly downstream of the word/frame generator and driving the panel pins `col_data` / `col_activate`. It accepts a full frame image through a load strobe and double-buffers it. It then drives one column at a time, with a programmable dwell and an anti-ghosting blank gap, and wraps continuously. New frames take effect only at a frame boundary, so the panel never shows a torn image.

## Interface
- `NUM_COLS`, 24: number of panel columns (≥2).
- `ROWS`, 7: rows per column.
- `DWELL`, 50000: clock cycles each column is driven (≥1).
- `BLANK`, 100: all-off clock cycles between columns (≥0).
- `clk` input 1: system clock, rising-edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `load` input 1: frame load strobe; `frame_in` is sampled on every cycle `load`=1.
- `frame_in` input NUM_COLS*ROWS: frame image. Column c is `frame_in[c*ROWS +: ROWS]`; bit r = row r; 1 = LED on.
- `col_data` output ROWS: row pattern of the currently driven column.
- `col_activate` output NUM_COLS: one-hot column enable; all-zero while blanking.
- `frame_start` output 1: one-cycle pulse on the first drive cycle of column 0.

## Operation
- Storage: `shadow` (pending frame), `active` (displayed frame), `pending` flag, column index `idx` (0..NUM_COLS-1), phase counter.
- FSM states:
  - DRIVE: `col_activate` = 1<<idx and `col_data` = active column idx. Lasts DWELL cycles, then goes to BLANK; if BLANK=0 it advances idx and stays in DRIVE.
  - BLANK: `col_activate`=0, `col_data`=0. Lasts BLANK cycles, then advances idx and enters DRIVE.
- Advance: idx+1; at NUM_COLS-1 it wraps to 0 (a frame boundary).
- Load: `load`=1 → `shadow` ← `frame_in`, `pending` ← 1. Repeated loads overwrite `shadow`; the last load before the boundary wins.
- Swap: on the transition into column-0 DRIVE, if `pending`, then `active` ← `shadow` and `pending` ← 0.
  - If `load`=1 on that same cycle, `active` ← `frame_in` directly (bypass), `shadow` ← `frame_in`, `pending` ← 0.
- `load` never interrupts or restarts the scan.
- `frame_start` is 1 exactly on the first DRIVE cycle of column 0, every frame.
- Reset:
  - All of these reset to 0: `col_data`, `col_activate`, `frame_start`, `active`, `shadow`, `pending`.
  - idx resets to NUM_COLS-1 and the state resets to BLANK, so the first advance wraps to column 0 and performs a swap.
  - With BLANK=0, the post-reset BLANK state still lasts exactly 1 cycle.
- Reset mid-scan: outputs go to 0 immediately (asynchronously). A frame loaded but not yet swapped is discarded.

## Timing
- All outputs are registered. `col_activate`, `col_data` and `frame_start` change on the same clock edge.
- After `rst_n` release, the first column-0 drive is visible after max(BLANK,1) rising edges.
- Column period = DWELL+BLANK cycles. Frame period = NUM_COLS*(DWELL+BLANK).
- Load-to-display latency:
  - `frame_in` sampled at edge k appears at the next column-0 drive after edge k.
  - This includes the boundary edge itself (bypass case).
  - Worst case is one frame period.
- `col_activate` is never more than one-hot. There is no cycle with two columns lit, including across wrap and swap.
- `col_data` is 0 whenever `col_activate` is 0.

## Test plan
All scenarios use NUM_COLS=24, ROWS=7, DWELL=4, BLANK=1 unless stated otherwise.
- Reset/first frame:
  - Stimulus: hold `rst_n`=0, then release with no load.
  - Required: all outputs are 0 during reset. After 1 edge, `col_activate`=24'h000001, `col_data`=0, `frame_start`=1 for 1 cycle.
  - Scan continues with a column period of 5 cycles and `frame_start` every 120 cycles.
- Pattern scan:
  - Stimulus: load a frame with column c = c[6:0] (c=0..23).
  - Required: in the next frame, the drive of column c shows `col_activate`=1<<c and `col_data`=c for exactly 4 cycles, followed by 1 all-zero cycle.
- Mid-frame load:
  - Stimulus: frame A is displayed; load frame B (all 7'h7F) while column 10 is driven.
  - Required: columns 11–23 still show A. The first B data (7'h7F) appears at the next `frame_start`.
- Double load / boundary bypass:
  - Stimulus: load C, then D, within one frame. Separately, assert `load` with E exactly on the boundary edge.
  - Required: D is displayed (never C). E is displayed in the frame starting at that edge.
- Async reset mid-scan:
  - Stimulus: drop `rst_n` while column 7 is driven, with a pending frame loaded.
  - Required: `col_activate`/`col_data` go to 0 without waiting for a clock edge. After release, the panel displays an all-zero frame.
- BLANK=0, DWELL=1:
  - Required: `col_activate` walks one bit per cycle, 1 → 2 → … → 24'h800000 → 1, with no zero cycles after the first frame.

Source files
------------

// File: rtl/column_scan_driver.sv
// Time-multiplexed column scanner for the LED word panel.
// Double-buffers a full frame and drives one column at a time with dwell and blank gap.
module column_scan_driver #(
  parameter int unsigned NUM_COLS = 24,
  parameter int unsigned ROWS     = 7,
  parameter int unsigned DWELL    = 50000,
  parameter int unsigned BLANK    = 100
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [NUM_COLS*ROWS-1:0] frame_in,
  output logic [ROWS-1:0]          col_data,
  output logic [NUM_COLS-1:0]      col_activate,
  output logic                     frame_start
);

  localparam int unsigned IDX_W     = $clog2(NUM_COLS);
  localparam int unsigned PH_MAX    = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int unsigned PH_W      = $clog2(PH_MAX + 1);
  localparam int unsigned BLANK_LEN = (BLANK == 0) ? 1 : BLANK;

  localparam logic [PH_W-1:0]  DRIVE_LAST = PH_W'(DWELL - 1);
  localparam logic [PH_W-1:0]  BLANK_LAST = PH_W'(BLANK_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_COL   = IDX_W'(NUM_COLS - 1);

  typedef logic [NUM_COLS-1:0][ROWS-1:0] frame_t;
  typedef enum logic {ST_DRIVE, ST_BLANK} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  frame_t            shadow_q, shadow_d;
  frame_t            active_q, active_d;
  frame_t            frame_in_cols;
  logic              pending_q, pending_d;
  logic              advance;
  logic              wrap;
  logic [ROWS-1:0]     col_data_d;
  logic [NUM_COLS-1:0] col_activate_d;
  logic                frame_start_d;

  assign frame_in_cols = frame_in;

  // State register; reset parks on the last column in BLANK so the first advance wraps and swaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BLANK;
      idx_q        <= LAST_COL;
      phase_q      <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      col_data     <= '0;
      col_activate <= '0;
      frame_start  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      phase_q      <= phase_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      col_data     <= col_data_d;
      col_activate <= col_activate_d;
      frame_start  <= frame_start_d;
    end
  end

  // Next state, frame buffering and the registered panel outputs.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    phase_d        = phase_q + PH_W'(1);
    shadow_d       = shadow_q;
    active_d       = active_q;
    pending_d      = pending_q;
    advance        = 1'b0;
    col_data_d     = '0;
    col_activate_d = '0;
    frame_start_d  = 1'b0;

    unique case (state_q)
      ST_DRIVE: begin
        if (phase_q == DRIVE_LAST) begin
          phase_d = '0;
          if (BLANK == 0) advance = 1'b1;
          else            state_d = ST_BLANK;
        end
      end
      ST_BLANK: begin
        if (phase_q == BLANK_LAST) begin
          phase_d = '0;
          state_d = ST_DRIVE;
          advance = 1'b1;
        end
      end
      default: state_d = ST_BLANK;
    endcase

    wrap = advance && (idx_q == LAST_COL);
    if (advance) idx_d = wrap ? '0 : idx_q + IDX_W'(1);

    if (load) begin
      shadow_d  = frame_in_cols;
      pending_d = 1'b1;
    end

    // A load on the boundary edge bypasses the shadow so it is shown in the frame starting now.
    if (wrap) begin
      if (load)           active_d = frame_in_cols;
      else if (pending_q) active_d = shadow_q;
      pending_d = 1'b0;
    end

    if (state_d == ST_DRIVE) begin
      col_activate_d = NUM_COLS'(1) << idx_d;
      col_data_d     = active_d[idx_d];
    end
    frame_start_d = wrap;
  end

endmodule

// File: tb/tb_column_scan_driver.sv
// Directed bench for column_scan_driver: expected panel cycles are queued per frame and popped per clock.
module tb_column_scan_driver;

  localparam int NC = 24;
  localparam int NR = 7;
  localparam int FW = NC * NR;
  localparam int FRAME_CYC = NC * 5;

  typedef struct {
    logic [NC-1:0] act;
    logic [NR-1:0] data;
    logic          fs;
    string         tag;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic [FW-1:0] frame_in = '0;
  logic [NR-1:0] d0_data;
  logic [NC-1:0] d0_act;
  logic          d0_fs;

  logic          d1_load = 1'b0;
  logic [FW-1:0] d1_frame = '0;
  logic [NR-1:0] d1_data;
  logic [NC-1:0] d1_act;
  logic          d1_fs;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];

  logic [FW-1:0] f_zero, f_pat, f_b, f_c, f_d, f_e, f_f;

  column_scan_driver #(.NUM_COLS(NC), .ROWS(NR), .DWELL(4), .BLANK(1)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .frame_in(frame_in),
    .col_data(d0_data), .col_activate(d0_act), .frame_start(d0_fs)
  );

  column_scan_driver #(.NUM_COLS(NC), .ROWS(NR), .DWELL(1), .BLANK(0)) dut_fast (
    .clk(clk), .rst_n(rst_n), .load(d1_load), .frame_in(d1_frame),
    .col_data(d1_data), .col_activate(d1_act), .frame_start(d1_fs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Queue one full frame of expected panel cycles: 4 drive cycles then 1 blank per column.
  task automatic push_frame(input logic [FW-1:0] f, input string tag);
    exp_t e;
    for (int c = 0; c < NC; c++) begin
      for (int k = 0; k < 5; k++) begin
        e.act  = (k < 4) ? (NC'(1) << c) : '0;
        e.data = (k < 4) ? f[c*NR +: NR] : '0;
        e.fs   = (c == 0) && (k == 0);
        e.tag  = $sformatf("%s_c%0d_k%0d", tag, c, k);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic tick_check();
    exp_t e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      chk("queue_underflow", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({e.tag, "_act"},  32'(d0_act),  32'(e.act));
      chk({e.tag, "_data"}, 32'(d0_data), 32'(e.data));
      chk({e.tag, "_fs"},   32'(d0_fs),   32'(e.fs));
    end
    load = 1'b0;
  endtask

  // Run one frame, optionally loading at two positions or dropping reset at rst_pos.
  task automatic run_frame(input logic [FW-1:0] exp_f, input string tag,
                           input int lp1, input logic [FW-1:0] lf1,
                           input int lp2, input logic [FW-1:0] lf2,
                           input int rst_pos);
    push_frame(exp_f, tag);
    for (int p = 0; p < FRAME_CYC; p++) begin
      tick_check();
      if (p == lp1) begin load = 1'b1; frame_in = lf1; end
      if (p == lp2) begin load = 1'b1; frame_in = lf2; end
      if (p == rst_pos) begin
        chk("pre_rst_col7_act", 32'(d0_act), 32'(NC'(1) << 7));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_act", 32'(d0_act), 32'd0);
        chk("async_rst_data", 32'(d0_data), 32'd0);
        chk("async_rst_fs", 32'(d0_fs), 32'd0);
        load = 1'b0;
        exp_q.delete();
        return;
      end
    end
  endtask

  initial begin
    for (int c = 0; c < NC; c++) begin
      f_zero[c*NR +: NR] = '0;
      f_pat[c*NR +: NR]  = NR'(c);
      f_b[c*NR +: NR]    = 7'h7F;
      f_c[c*NR +: NR]    = 7'h55;
      f_d[c*NR +: NR]    = 7'h2A;
      f_e[c*NR +: NR]    = NR'(c * 5 + 3);
      f_f[c*NR +: NR]    = NR'(~c);
    end

    // Reset: all outputs low.
    repeat (3) @(negedge clk);
    chk("rst_act", 32'(d0_act), 32'd0);
    chk("rst_data", 32'(d0_data), 32'd0);
    chk("rst_fs", 32'(d0_fs), 32'd0);
    rst_n = 1'b1;

    // Frame 0: empty frame; load column-index pattern mid-frame.
    run_frame(f_zero, "f0_zero", 60, f_pat, -1, f_zero, -1);
    // Frame 1: pattern; load B during column 10 drive.
    run_frame(f_pat, "f1_pat", 50, f_b, -1, f_zero, -1);
    // Frame 2: B; load C then D, D must win.
    run_frame(f_b, "f2_b", 10, f_c, 80, f_d, -1);
    // Frame 3: D; load E on the boundary edge.
    run_frame(f_d, "f3_d", FRAME_CYC - 1, f_e, -1, f_zero, -1);
    // Frame 4: E via bypass; load F then reset during column 7.
    run_frame(f_e, "f4_e", 20, f_f, -1, f_zero, 36);

    repeat (2) @(negedge clk);
    chk("rst2_act", 32'(d0_act), 32'd0);
    rst_n = 1'b1;
    run_frame(f_zero, "f5_post_rst", -1, f_zero, -1, f_zero, -1);
    run_frame(f_zero, "f6_zero", -1, f_zero, -1, f_zero, -1);

    // Fast instance: one column per cycle with no gaps.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("fast_rst_act", 32'(d1_act), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3 * NC; i++) begin
      @(negedge clk);
      chk($sformatf("fast_act_%0d", i), 32'(d1_act), 32'(NC'(1) << (i % NC)));
      chk($sformatf("fast_data_%0d", i), 32'(d1_data), 32'd0);
      chk($sformatf("fast_fs_%0d", i), 32'(d1_fs), 32'((i % NC) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
